// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: AES-128 key expansion controller.
// A single key_generation datapath is reused for rounds 1..10, one round per
// clock, filling an 11-entry round-key store that is read through a
// registered port.
// Optional build macro: KEY_SCHED_ZEROIZE_EN adds the zeroize port, which
// scrubs the round-key store and the read register.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no valid schedule; waiting for start
// EXPAND | one round key produced per cycle, round_cnt = round being built
// DONE   | all 11 round keys valid; start launches a fresh expansion
module key_schedule_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [3:0]   rd_round,
`ifdef KEY_SCHED_ZEROIZE_EN
    input  logic         zeroize,
`endif
    output logic         busy,
    output logic         keys_valid,
    output logic         start_err,
    output logic [127:0] rd_key
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state, state_nx;
    logic [3:0]   round_cnt, round_cnt_nx;
    logic         start_err_nx;
    logic         load_key;
    logic         rk_we;
    logic [3:0]   prev_idx;
    logic [127:0] kg_out;
    logic [127:0] rk [0:10];

`ifdef KEY_SCHED_ZEROIZE_EN
    logic zero_req;
    assign zero_req = zeroize;
`else
    localparam logic zero_req = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // S-box as multiplicative inverse (a^254, so 0 maps to 0) plus affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] p;
        inv = 8'h01;
        p   = a;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round_num);
        case (round_num)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_generation(input logic [127:0] prev,
                                                    input logic [3:0]   round_num);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = prev[127:96];
        w1 = prev[95:64];
        w2 = prev[63:32];
        w3 = prev[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon(round_num), 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // the only key_generation instance; round_cnt is never 0 while it is used
    assign prev_idx = (round_cnt == 4'd0) ? 4'd0 : round_cnt - 4'd1;
    assign kg_out   = key_generation(rk[prev_idx], round_cnt);

    assign busy       = (state == EXPAND);
    assign keys_valid = (state == DONE);

    // state register, round counter and start_err flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            round_cnt <= 4'd0;
            start_err <= 1'b0;
        end else begin
            state     <= state_nx;
            round_cnt <= round_cnt_nx;
            start_err <= start_err_nx;
        end
    end

    // next-state decode; zeroize overrides start and suppresses start_err
    always_comb begin
        state_nx     = state;
        round_cnt_nx = round_cnt;
        start_err_nx = 1'b0;
        load_key     = 1'b0;
        rk_we        = 1'b0;
        if (zero_req) begin
            state_nx     = IDLE;
            round_cnt_nx = 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nx     = EXPAND;
                        round_cnt_nx = 4'd1;
                        load_key     = 1'b1;
                    end
                end
                EXPAND: begin
                    rk_we        = 1'b1;
                    start_err_nx = start;
                    if (round_cnt == 4'd10) begin
                        state_nx     = DONE;
                        round_cnt_nx = 4'd0;
                    end else begin
                        round_cnt_nx = round_cnt + 4'd1;
                    end
                end
                default: begin
                    state_nx     = IDLE;
                    round_cnt_nx = 4'd0;
                end
            endcase
        end
    end

    // round-key store; deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (zero_req) begin
                for (int i = 0; i < 11; i++) rk[i] <= '0;
            end else if (load_key) begin
                rk[0] <= key_in;
            end else if (rk_we) begin
                rk[round_cnt] <= kg_out;
            end
        end
    end

    // registered read port, no write bypass; out-of-range indices read zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_key <= '0;
        end else if (zero_req) begin
            rd_key <= '0;
        end else if (rd_round <= 4'd10) begin
            rd_key <= rk[rd_round];
        end else begin
            rd_key <= '0;
        end
    end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 clk  input  1  single clock; all state changes on the rising edge.
REQ-002 rst_n  input  1  reset, synchronous and active-low.
REQ-003 start  input  1  request expansion of key_in; sampled on each rising edge.
REQ-004 key_in  input  128  AES-128 cipher key; becomes round key 0.
REQ-005 rd_round  input  4  round-key read index, 0..10.
REQ-006 zeroize  input  1  storage clear request; present only when KEY_SCHED_ZEROIZE_EN is defined.
REQ-007 busy  output  1  high while expansion is in progress.
REQ-008 keys_valid  output  1  high when all 11 round keys hold a completed expansion.
REQ-009 start_err  output  1  one-cycle pulse when start is sampled while busy.
REQ-010 rd_key  output  128  registered round key selected by rd_round.

Function
REQ-011 The block shall instantiate exactly one key_generation datapath and shall reuse it for all 10 rounds, one round per cycle.
REQ-012 The state machine shall have three states: IDLE, EXPAND and DONE.
REQ-013 IDLE/DONE + start: on that edge, rk[0] <= key_in, round_cnt <= 1, keys_valid <= 0, busy <= 1, next state EXPAND.
REQ-014 EXPAND, each edge: rk[round_cnt] <= key_generation(rk[round_cnt-1], round_cnt), round_cnt <= round_cnt+1.
REQ-015 EXPAND with round_cnt==10 on an edge: after writing rk[10], next state DONE, busy <= 0, keys_valid <= 1, round_cnt <= 0.
REQ-016 Latency: for start sampled at edge T, rk[k] shall be written at edge T+k, and keys_valid shall be high after edge T+10.
REQ-017 start sampled while in EXPAND shall be ignored, expansion shall continue unaffected, and start_err shall be high for the following cycle only.
REQ-018 DONE shall hold keys_valid=1 indefinitely until start, reset or zeroize.
REQ-019 round_cnt shall be 4 bits, shall never exceed 10, and shall be driven as round_num to the datapath; rcon for rounds 1..10 comes from that datapath.
REQ-020 rd_key <= rk[rd_round] every edge when rd_round<=10; rd_key <= 0 when rd_round is 11..15.
REQ-021 Read latency shall be 1 cycle; reads are permitted in any state.
REQ-022 A read during EXPAND shall return the current register contents; the value is meaningful only for rounds already written.
REQ-023 A write and a read of the same rk entry on the same edge shall return the old value (no bypass).

Reset
REQ-024 On rst_n==0 at a rising edge, the following shall hold: state=IDLE, round_cnt=0, busy=0, keys_valid=0, start_err=0, rd_key=0.
REQ-025 Reset shall take priority over start and zeroize, and shall abort an expansion in progress.
REQ-026 rk[0..10] shall not be cleared by reset.

Configuration
REQ-027 Macro KEY_SCHED_ZEROIZE_EN, when defined: the zeroize port shall exist.
REQ-028 With KEY_SCHED_ZEROIZE_EN defined, zeroize=1 at an edge shall clear rk[0..10] and rd_key to 0, force IDLE, and set busy=0 and keys_valid=0.
REQ-029 With KEY_SCHED_ZEROIZE_EN defined, zeroize shall take priority over start, and no start_err shall be raised.
REQ-030 When KEY_SCHED_ZEROIZE_EN is undefined, the zeroize port and its clear logic shall be absent, and all other behaviour shall be identical.

Verification
REQ-031 Reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c -> busy for 10 cycles; keys_valid at T+10; rd_round=1 -> rd_key=a0fafe1788542cb123a339392a6c7605; rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 start pulsed at T+4 during expansion -> start_err high exactly at T+5; final rk[10] still d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-033 rst_n low at T+5 -> next cycle busy=0, keys_valid=0, rd_key=0; new start with key 000102030405060708090a0b0c0d0e0f -> rk[10]=13111d7fe3944a17f307a78b4d2b30c5.
REQ-034 rd_round=0..15 sweep in DONE -> rounds 0..10 match the FIPS-197 schedule one cycle later; rounds 11..15 read 0.
REQ-035 Back-to-back start in DONE -> keys_valid drops the next cycle and returns after 10 cycles with the new schedule.
REQ-036 KEY_SCHED_ZEROIZE_EN defined: zeroize with start at T+3 -> IDLE, all rd_round reads 0, start_err=0.
